// File: rtl/winograd_pe_issue_ctrl.sv
// Winograd PE core issue controller.
// Takes one weight beat per channel group and a stream of feature tiles, then
// drives them into the PE core. Partial sums of every group but the last go
// through the core's inter-result FIFO. Core out_valid pulses of the final group
// are counted to detect pass completion.
// Optional build macro: PE_ISSUE_PERF_EN adds the perf_stall/perf_active counters.
module winograd_pe_issue_ctrl #(
   parameter int unsigned FEATURE_SIZE = 4,
   parameter int unsigned WEIGHT_SIZE  = 3,
   parameter int unsigned DATA_BIT     = 8,
   parameter int unsigned WEIGHT_BIT   = 8,
   parameter int unsigned MESH_N       = 8,
   parameter int unsigned X_PE         = 8,
   parameter int unsigned BIAS_BIT     = 20,
   parameter int unsigned TILE_W       = 11,
   parameter int unsigned CG_W         = 8,
   parameter int unsigned GROUP_GAP    = 8
) (
   input  logic                                                   clk,
   input  logic                                                   rst_n,
   input  logic                                                   start,
   input  logic [TILE_W-1:0]                                      cfg_tiles,
   input  logic [CG_W-1:0]                                        cfg_cgroups,
   input  logic                                                   cfg_poolop,
   input  logic [BIAS_BIT*X_PE-1:0]                               bias_in,
   input  logic                                                   w_valid,
   output logic                                                   w_ready,
   input  logic [WEIGHT_BIT*MESH_N*WEIGHT_SIZE*WEIGHT_SIZE*X_PE-1:0] w_data,
   input  logic                                                   f_valid,
   output logic                                                   f_ready,
   input  logic [DATA_BIT*MESH_N*FEATURE_SIZE*FEATURE_SIZE-1:0]   f_data,
   output logic                                                   pe_in_valid,
   output logic [DATA_BIT*MESH_N*FEATURE_SIZE*FEATURE_SIZE-1:0]   pe_feature,
   output logic [WEIGHT_BIT*MESH_N*WEIGHT_SIZE*WEIGHT_SIZE*X_PE-1:0] pe_weight,
   output logic                                                   pe_tofifo,
   output logic                                                   pe_fromfifo,
   output logic [BIAS_BIT*X_PE-1:0]                               pe_bias,
   output logic                                                   pe_bias_valid,
   output logic                                                   pe_poolop,
   input  logic                                                   pe_out_valid,
   output logic                                                   busy,
`ifdef PE_ISSUE_PERF_EN
   output logic [31:0]                                            perf_stall,
   output logic [31:0]                                            perf_active,
`endif
   output logic                                                   done
);

   localparam int unsigned GAP_W = (GROUP_GAP > 1) ? $clog2(GROUP_GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_ISSUE,
      S_GAP,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [TILE_W-1:0] tiles, tile_cnt, out_count;
   logic [CG_W-1:0]   cgroups, grp;
   logic [GAP_W-1:0]  gap_cnt;
   logic              start_acc, w_hs, f_hs;
   logic              last_tile, last_grp, gap_end, out_done, count_en;

   assign start_acc = start && (state == S_IDLE);
   assign w_hs      = w_valid && (state == S_LOAD_W);
   assign f_hs      = f_valid && (state == S_ISSUE);
   assign last_tile = (tile_cnt == tiles - TILE_W'(1));
   assign last_grp  = (grp == cgroups - CG_W'(1));
   assign gap_end   = (gap_cnt == GAP_W'(GROUP_GAP - 1));
   assign out_done  = (out_count == tiles);
   // Final results arrive while the last group issues, during its trailing gap,
   // or in DRAIN; anything earlier is a partial sum headed for the inter-FIFO.
   assign count_en  = pe_out_valid && !out_done &&
                      ((last_grp && (state == S_ISSUE || state == S_GAP)) ||
                       (state == S_DRAIN));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start)              state_nxt = S_LOAD_W;
         S_LOAD_W: if (w_valid)            state_nxt = S_ISSUE;
         S_ISSUE:  if (f_hs && last_tile)  state_nxt = S_GAP;
         S_GAP:    if (gap_end)            state_nxt = last_grp ? S_DRAIN : S_LOAD_W;
         S_DRAIN:  if (out_done)           state_nxt = S_DONE;
         S_DONE:                           state_nxt = S_IDLE;
         default:                          state_nxt = S_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      w_ready = 1'b0;
      f_ready = 1'b0;
      busy    = 1'b1;
      done    = 1'b0;
      case (state)
         S_IDLE:   busy    = 1'b0;
         S_LOAD_W: w_ready = 1'b1;
         S_ISSUE:  f_ready = 1'b1;
         S_DONE:   done    = 1'b1;
         default:  ;
      endcase
   end

   // Pass configuration captured on start accept; zero counts behave as one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tiles     <= '0;
         cgroups   <= '0;
         pe_bias   <= '0;
         pe_poolop <= 1'b0;
      end else if (start_acc) begin
         tiles     <= (cfg_tiles == '0) ? TILE_W'(1) : cfg_tiles;
         cgroups   <= (cfg_cgroups == '0) ? CG_W'(1) : cfg_cgroups;
         pe_bias   <= bias_in;
         pe_poolop <= cfg_poolop;
      end
   end

   // Tile, group, gap and result counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tile_cnt  <= '0;
         grp       <= '0;
         gap_cnt   <= '0;
         out_count <= '0;
      end else begin
         if (start_acc)  tile_cnt <= '0;
         else if (f_hs)  tile_cnt <= last_tile ? '0 : tile_cnt + TILE_W'(1);

         if (start_acc)                                 grp <= '0;
         else if (state == S_GAP && gap_end && !last_grp) grp <= grp + CG_W'(1);

         if (state == S_GAP) gap_cnt <= gap_end ? '0 : gap_cnt + GAP_W'(1);
         else                gap_cnt <= '0;

         if (start_acc)     out_count <= '0;
         else if (count_en) out_count <= out_count + TILE_W'(1);
      end
   end

   // Core-facing datapath: weight held per group, feature issued one cycle after handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_weight     <= '0;
         pe_feature    <= '0;
         pe_in_valid   <= 1'b0;
         pe_tofifo     <= 1'b0;
         pe_fromfifo   <= 1'b0;
         pe_bias_valid <= 1'b0;
      end else begin
         if (w_hs) pe_weight <= w_data;
         if (f_hs) pe_feature <= f_data;
         pe_in_valid   <= f_hs;
         pe_tofifo     <= f_hs && !last_grp;
         pe_fromfifo   <= f_hs && (grp != '0);
         pe_bias_valid <= f_hs && (grp == '0);
      end
   end

`ifdef PE_ISSUE_PERF_EN
   // Saturating stall / activity counters, cleared when a pass is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall  <= '0;
         perf_active <= '0;
      end else if (start_acc) begin
         perf_stall  <= '0;
         perf_active <= '0;
      end else begin
         if (state == S_ISSUE && !f_valid && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
         if (state != S_IDLE && perf_active != '1)             perf_active <= perf_active + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_winograd_pe_issue_ctrl.sv
// Self-checking bench for winograd_pe_issue_ctrl with a randomized feature,
// weight and core-response environment and a transaction-level expectation model.
// Build with PE_ISSUE_PERF_EN defined to also check the perf counters.
module tb_winograd_pe_issue_ctrl;

   localparam int unsigned FW     = 1024;  // 8*8*4*4
   localparam int unsigned WW     = 4608;  // 8*8*3*3*8
   localparam int unsigned BW     = 160;   // 20*8
   localparam int unsigned TILE_W = 11;
   localparam int unsigned CG_W   = 8;
   localparam int unsigned GAP    = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [TILE_W-1:0] cfg_tiles = '0;
   logic [CG_W-1:0]   cfg_cgroups = '0;
   logic              cfg_poolop = 1'b0;
   logic [BW-1:0]     bias_in = '0;
   logic              w_valid = 1'b0;
   logic              w_ready;
   logic [WW-1:0]     w_data = '0;
   logic              f_valid = 1'b0;
   logic              f_ready;
   logic [FW-1:0]     f_data = '0;
   logic              pe_in_valid;
   logic [FW-1:0]     pe_feature;
   logic [WW-1:0]     pe_weight;
   logic              pe_tofifo, pe_fromfifo, pe_bias_valid, pe_poolop;
   logic [BW-1:0]     pe_bias;
   logic              pe_out_valid = 1'b0;
   logic              busy, done;
`ifdef PE_ISSUE_PERF_EN
   logic [31:0]       perf_stall, perf_active;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [FW-1:0] last_feat = '0;

   always #5 clk = ~clk;

   winograd_pe_issue_ctrl #(
      .FEATURE_SIZE(4), .WEIGHT_SIZE(3), .DATA_BIT(8), .WEIGHT_BIT(8), .MESH_N(8),
      .X_PE(8), .BIAS_BIT(20), .TILE_W(TILE_W), .CG_W(CG_W), .GROUP_GAP(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_tiles(cfg_tiles),
      .cfg_cgroups(cfg_cgroups), .cfg_poolop(cfg_poolop), .bias_in(bias_in),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
      .pe_in_valid(pe_in_valid), .pe_feature(pe_feature), .pe_weight(pe_weight),
      .pe_tofifo(pe_tofifo), .pe_fromfifo(pe_fromfifo), .pe_bias(pe_bias),
      .pe_bias_valid(pe_bias_valid), .pe_poolop(pe_poolop),
      .pe_out_valid(pe_out_valid), .busy(busy),
`ifdef PE_ISSUE_PERF_EN
      .perf_stall(perf_stall), .perf_active(perf_active),
`endif
      .done(done)
   );

   function automatic logic [WW-1:0] rand_wide();
      logic [WW-1:0] v;
      for (int i = 0; i < int'(WW / 32); i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic bit outputs_zero();
      bit z;
      z = (pe_in_valid === 1'b0) && (pe_feature === '0) && (pe_weight === '0) &&
          (pe_tofifo === 1'b0) && (pe_fromfifo === 1'b0) && (pe_bias === '0) &&
          (pe_bias_valid === 1'b0) && (pe_poolop === 1'b0) && (w_ready === 1'b0) &&
          (f_ready === 1'b0) && (busy === 1'b0) && (done === 1'b0);
`ifdef PE_ISSUE_PERF_EN
      z = z && (perf_stall === '0) && (perf_active === '0);
`endif
      return z;
   endfunction

   // One complete pass. smode: 0 f_valid always high, 1 random stalls,
   // 2 toggling 1,0,1,0 in ISSUE, 3 exactly five leading ISSUE stalls.
   task automatic run_pass(input int unsigned t_cfg, input int unsigned g_cfg,
                           input int unsigned lat, input int unsigned smode);
      int unsigned   t_n, g_n, k, wcnt, pulses, cyc, busy_cnt, stall_cnt;
      int unsigned   last_valid, budget, stalls_left, g;
      bit            hs_prev, done_seen, tog, fv, wv;
      logic [FW-1:0] exp_feat;
      logic [WW-1:0] wtmp;
      logic [BW-1:0] bias_v;
      logic          pool_v;
      logic [2:0]    exp_flags;
      logic [WW-1:0] wq[$];
      int unsigned   oq[$];

      t_n = (t_cfg == 0) ? 1 : t_cfg;
      g_n = (g_cfg == 0) ? 1 : g_cfg;
      wtmp   = rand_wide();
      bias_v = wtmp[BW-1:0];
      pool_v = 1'($urandom_range(0, 1));
      cfg_tiles    = TILE_W'(t_cfg);
      cfg_cgroups  = CG_W'(g_cfg);
      cfg_poolop   = pool_v;
      bias_in      = bias_v;
      f_valid      = 1'b0;
      w_valid      = 1'b0;
      pe_out_valid = 1'b0;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL start_busy: got %b required 1", busy);
      end

      k = 0; wcnt = 0; pulses = 0; cyc = 0; busy_cnt = 0; stall_cnt = 0;
      last_valid = 0; hs_prev = 1'b0; done_seen = 1'b0; tog = 1'b1;
      stalls_left = 5; exp_feat = '0;
      budget = 100 + g_n * (4 * t_n + 40) + lat;

      while (1) begin
         checks++;
         if (pe_in_valid !== hs_prev) begin
            errors++;
            $display("FAIL in_valid cyc=%0d: got %b required %b", cyc, pe_in_valid, hs_prev);
         end else if (hs_prev) begin
            g = k / t_n;
            checks++;
            if (pe_feature !== exp_feat) begin
               errors++;
               $display("FAIL feature tile=%0d: got low %h required low %h", k,
                        pe_feature[63:0], exp_feat[63:0]);
            end
            exp_flags = {(g != g_n - 1), (g != 0), (g == 0)};
            checks++;
            if ({pe_tofifo, pe_fromfifo, pe_bias_valid} !== exp_flags) begin
               errors++;
               $display("FAIL flags tile=%0d grp=%0d: got %b required %b", k, g,
                        {pe_tofifo, pe_fromfifo, pe_bias_valid}, exp_flags);
            end
            checks++;
            if (g >= wq.size()) begin
               errors++;
               $display("FAIL weight grp=%0d: got issue required weight beat first (beats=%0d)",
                        g, wq.size());
            end else if (pe_weight !== wq[g]) begin
               errors++;
               $display("FAIL weight grp=%0d: got low %h required low %h", g,
                        pe_weight[63:0], wq[g][63:0]);
            end
            checks++;
            if (pe_bias !== bias_v || pe_poolop !== pool_v) begin
               errors++;
               $display("FAIL bias_pool: got %h/%b required %h/%b", pe_bias, pe_poolop,
                        bias_v, pool_v);
            end
            if (k > 0 && (k % t_n) == 0) begin
               checks++;
               if (cyc - last_valid - 1 < GAP) begin
                  errors++;
                  $display("FAIL group_gap grp=%0d: got %0d idle required >=%0d", g,
                           cyc - last_valid - 1, GAP);
               end
            end
            k++;
            last_valid = cyc;
            last_feat  = exp_feat;
         end else begin
            checks++;
            if (pe_feature !== last_feat) begin
               errors++;
               $display("FAIL feature_hold cyc=%0d: got low %h required low %h", cyc,
                        pe_feature[63:0], last_feat[63:0]);
            end
         end
         if (pe_in_valid === 1'b1) oq.push_back(cyc + lat);

         if (done === 1'b1) begin
            done_seen = 1'b1;
            checks++;
            if (pulses != g_n * t_n || oq.size() != 0) begin
               errors++;
               $display("FAIL done_early: got pulses=%0d required %0d", pulses, g_n * t_n);
            end
            checks++;
            if (k != g_n * t_n || wcnt != g_n) begin
               errors++;
               $display("FAIL pass_counts: got issues=%0d wbeats=%0d required %0d/%0d",
                        k, wcnt, g_n * t_n, g_n);
            end
`ifdef PE_ISSUE_PERF_EN
            checks++;
            if (perf_stall !== stall_cnt || perf_active !== busy_cnt) begin
               errors++;
               $display("FAIL perf: got stall=%0d active=%0d required %0d/%0d",
                        perf_stall, perf_active, stall_cnt, busy_cnt);
            end
`endif
            break;
         end
         if (cyc >= budget) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles required done", cyc);
            break;
         end
         if (busy === 1'b1) busy_cnt++;

         // drive next-cycle inputs
         if (oq.size() > 0 && oq[0] == cyc) begin
            void'(oq.pop_front());
            pe_out_valid = 1'b1;
            pulses++;
         end else begin
            pe_out_valid = 1'b0;
         end
         if (f_ready === 1'b1) begin
            case (smode)
               0: fv = 1'b1;
               1: fv = ($urandom_range(0, 2) != 0);
               2: begin fv = tog; tog = !tog; end
               default: begin
                  if (stalls_left > 0) begin fv = 1'b0; stalls_left--; end
                  else fv = 1'b1;
               end
            endcase
            if (!fv) stall_cnt++;
         end else begin
            fv = 1'($urandom_range(0, 1));
         end
         wtmp    = rand_wide();
         f_data  = wtmp[FW-1:0];
         f_valid = fv;
         hs_prev = fv && (f_ready === 1'b1);
         if (hs_prev) exp_feat = wtmp[FW-1:0];
         wv      = ($urandom_range(0, 3) != 0);
         w_data  = rand_wide();
         w_valid = wv;
         if (wv && w_ready === 1'b1) begin
            wq.push_back(w_data);
            wcnt++;
         end
         if (busy === 1'b1 && $urandom_range(0, 15) == 0) begin
            start       = 1'b1;
            cfg_tiles   = TILE_W'($urandom());
            cfg_cgroups = CG_W'($urandom());
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end

      start = 1'b0; f_valid = 1'b0; w_valid = 1'b0; pe_out_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL after_done: got busy=%b done=%b required 0/0 (done_seen=%b)",
                  busy, done, done_seen);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (!outputs_zero()) begin
         errors++;
         $display("FAIL reset_outputs: got vld/busy/done=%b%b%b required all outputs 0",
                  pe_in_valid, busy, done);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (!outputs_zero()) begin
         errors++;
         $display("FAIL reset_release_idle: got busy=%b required all outputs 0", busy);
      end
      last_feat = '0;
   endtask

   task automatic test_single_group();   run_pass(4, 1, 3, 0);  endtask
   task automatic test_multi_group();    run_pass(2, 3, 4, 0);  endtask
   task automatic test_stall_toggle();   run_pass(4, 1, 2, 2);  endtask
   task automatic test_partial_final();  run_pass(3, 2, 5, 0);  endtask
   task automatic test_drain_wait();     run_pass(3, 1, 20, 1); endtask
   task automatic test_zero_cfg();       run_pass(0, 0, 2, 0);  endtask
   task automatic test_perf_stall();     run_pass(4, 1, 3, 3);  endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         run_pass($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(1, 6), 1);
   endtask

   task automatic test_reset_mid();
      int unsigned seen;
      seen = 0;
      cfg_tiles = TILE_W'(8); cfg_cgroups = CG_W'(1); cfg_poolop = 1'b1;
      bias_in = {BW{1'b1}};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && seen < 2; i++) begin
         w_valid = 1'b1;
         f_valid = 1'b1;
         w_data  = rand_wide();
         f_data  = w_data[FW-1:0];
         @(negedge clk);
         if (pe_in_valid === 1'b1) seen++;
      end
      checks++;
      if (seen < 2) begin
         errors++;
         $display("FAIL reset_mid_setup: got %0d issues required 2", seen);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (!outputs_zero()) begin
         errors++;
         $display("FAIL reset_mid_async: got vld/busy/fr/flags=%b%b%b%b%b%b required 0",
                  pe_in_valid, busy, f_ready, pe_tofifo, pe_fromfifo, pe_bias_valid);
      end
      w_valid = 1'b0; f_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (!outputs_zero()) begin
         errors++;
         $display("FAIL reset_mid_after: got busy=%b done=%b required 0/0", busy, done);
      end
      last_feat = '0;
      run_pass(5, 2, 3, 0);
   endtask

   initial begin
      test_reset();
      test_single_group();
      test_multi_group();
      test_stall_toggle();
      test_partial_final();
      test_drain_wait();
      test_zero_cfg();
      test_perf_stall();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
